// File: rtl/wager_bank.sv
// Multi-seat wager/balance bank: per-seat balance with escrowed wagers, placed while idle
// and settled one seat per clock once the round result is posted.
module wager_bank #(
  parameter int NSEAT    = 4,
  parameter int SEAT_W   = 2,
  parameter int BAL_W    = 8,
  parameter int WAG_W    = 8,
  parameter int INIT_BAL = 100,
  parameter int TIE_MULT = 8
) (
  input  logic              slow_clock,
  input  logic              resetb,
  input  logic              bet_valid,
  input  logic [SEAT_W-1:0] bet_seat,
  input  logic [1:0]        bet_type,
  input  logic [WAG_W-1:0]  bet_amount,
  output logic              bet_ok,
  output logic              bet_rej,
  input  logic              settle_start,
  input  logic [1:0]        result,
  output logic              busy,
  output logic              done,
  input  logic [SEAT_W-1:0] rd_seat,
  output logic [BAL_W-1:0]  rd_balance,
  output logic [WAG_W-1:0]  rd_wager,
  output logic [NSEAT-1:0]  seat_broke,
  output logic [1:0]        state_dbg
);

  // Handshake: bet_valid is a single-cycle request sampled only on the rising edge; exactly
  // one of bet_ok/bet_rej pulses the following cycle. settle_start is a single-cycle request
  // taken only in IDLE with a nonzero result; done pulses once per accepted start.

  localparam int SUM_W = BAL_W + $clog2(TIE_MULT + 2) + 1;
  localparam logic [SUM_W-1:0]  BAL_MAX = {{(SUM_W-BAL_W){1'b0}}, {BAL_W{1'b1}}};
  localparam logic [SEAT_W:0]   NSEAT_V = (SEAT_W+1)'(NSEAT);
  localparam logic [SEAT_W-1:0] LAST    = SEAT_W'(NSEAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BAL_W-1:0]  bal_q [NSEAT];
  logic [WAG_W-1:0]  wag_q [NSEAT];
  logic [1:0]        typ_q [NSEAT];
  logic [1:0]        res_q;
  logic [SEAT_W-1:0] idx_q;

  logic              settle_go;
  logic              bet_in_range;
  logic [BAL_W-1:0]  bet_bal;
  logic [WAG_W-1:0]  bet_wag;
  logic              bet_accept;
  logic [BAL_W-1:0]  cur_bal;
  logic [WAG_W-1:0]  cur_wag;
  logic [1:0]        cur_typ;
  logic [SUM_W-1:0]  credit;
  logic [SUM_W-1:0]  sum;
  logic [BAL_W-1:0]  new_bal;
  logic              rd_in_range;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    settle_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        settle_go = settle_start && (result != 2'b00);
        if (settle_go) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (idx_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_dbg = state_q;

  always_comb begin
    bet_in_range = ({1'b0, bet_seat} < NSEAT_V);
    bet_bal      = '0;
    bet_wag      = '0;
    if (bet_in_range) begin
      bet_bal = bal_q[bet_seat];
      bet_wag = wag_q[bet_seat];
    end
    // A start accepted in the same cycle wins over the bet.
    bet_accept = bet_valid && (state_q == S_IDLE) && !settle_go && bet_in_range &&
                 (bet_type != 2'b00) && (bet_amount != '0) &&
                 (BAL_W'(bet_amount) <= bet_bal) && (bet_wag == '0);
  end

  always_comb begin
    cur_bal = bal_q[idx_q];
    cur_wag = wag_q[idx_q];
    cur_typ = typ_q[idx_q];
    credit  = '0;
    if (cur_wag != '0) begin
      if (cur_typ == res_q && res_q == 2'b11)
        credit = SUM_W'(cur_wag) * SUM_W'(TIE_MULT + 1);
      else if (cur_typ == res_q)
        credit = SUM_W'(cur_wag) << 1;
      else if (res_q == 2'b11)
        credit = SUM_W'(cur_wag);
    end
    sum     = SUM_W'(cur_bal) + credit;
    new_bal = (sum > BAL_MAX) ? {BAL_W{1'b1}} : sum[BAL_W-1:0];
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NSEAT; i++) begin
        bal_q[i] <= BAL_W'(INIT_BAL);
        wag_q[i] <= '0;
        typ_q[i] <= 2'b00;
      end
      res_q   <= 2'b00;
      idx_q   <= '0;
      bet_ok  <= 1'b0;
      bet_rej <= 1'b0;
    end else begin
      bet_ok  <= bet_valid && bet_accept;
      bet_rej <= bet_valid && !bet_accept;
      if (settle_go) begin
        res_q <= result;
        idx_q <= '0;
      end
      if (bet_accept) begin
        bal_q[bet_seat] <= bet_bal - BAL_W'(bet_amount);
        wag_q[bet_seat] <= bet_amount;
        typ_q[bet_seat] <= bet_type;
      end
      if (state_q == S_SETTLE) begin
        bal_q[idx_q] <= new_bal;
        wag_q[idx_q] <= '0;
        typ_q[idx_q] <= 2'b00;
        idx_q        <= idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    rd_in_range = ({1'b0, rd_seat} < NSEAT_V);
    rd_balance  = '0;
    rd_wager    = '0;
    if (rd_in_range) begin
      rd_balance = bal_q[rd_seat];
      rd_wager   = wag_q[rd_seat];
    end
    seat_broke = '0;
    for (int i = 0; i < NSEAT; i++) seat_broke[i] = (bal_q[i] == '0);
  end

endmodule

// File: tb/tb_wager_bank.sv
// Directed bench for wager_bank: stimulus tasks push expectations into queues, and a
// negedge monitor pops them whenever a bet response, done pulse or read strobe appears.
module tb_wager_bank;

  localparam int NSEAT  = 4;
  localparam int SEAT_W = 2;
  localparam int BAL_W  = 8;
  localparam int WAG_W  = 8;
  localparam int RD_W   = 1 + NSEAT + BAL_W + WAG_W;

  logic              clk = 1'b0;
  logic              resetb;
  logic              bet_valid;
  logic [SEAT_W-1:0] bet_seat;
  logic [1:0]        bet_type;
  logic [WAG_W-1:0]  bet_amount;
  logic              bet_ok, bet_rej;
  logic              settle_start;
  logic [1:0]        result;
  logic              busy, done;
  logic [SEAT_W-1:0] rd_seat;
  logic [BAL_W-1:0]  rd_balance;
  logic [WAG_W-1:0]  rd_wager;
  logic [NSEAT-1:0]  seat_broke;
  logic [1:0]        state_dbg;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic rd_req = 1'b0;

  logic [1:0]      exp_bet_q[$];
  logic [RD_W-1:0] exp_rd_q[$];
  int              exp_done_q[$];

  wager_bank #(
    .NSEAT(NSEAT), .SEAT_W(SEAT_W), .BAL_W(BAL_W), .WAG_W(WAG_W),
    .INIT_BAL(100), .TIE_MULT(8)
  ) dut (
    .slow_clock(clk), .resetb(resetb),
    .bet_valid(bet_valid), .bet_seat(bet_seat), .bet_type(bet_type), .bet_amount(bet_amount),
    .bet_ok(bet_ok), .bet_rej(bet_rej),
    .settle_start(settle_start), .result(result), .busy(busy), .done(done),
    .rd_seat(rd_seat), .rd_balance(rd_balance), .rd_wager(rd_wager),
    .seat_broke(seat_broke), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Monitor
  always @(negedge clk) begin : monitor
    logic [1:0]      eb;
    logic [RD_W-1:0] er, ar;
    int              el, al;
    if (bet_ok || bet_rej) begin
      total++;
      if (exp_bet_q.size() == 0) begin
        bad++;
        $display("FAIL bet_resp: got ok=%0b rej=%0b, required no response", bet_ok, bet_rej);
      end else begin
        eb = exp_bet_q.pop_front();
        if ({bet_ok, bet_rej} !== eb) begin
          bad++;
          $display("FAIL bet_resp: got ok=%0b rej=%0b, required ok=%0b rej=%0b",
                   bet_ok, bet_rej, eb[1], eb[0]);
        end
      end
    end
    if (done) begin
      total++;
      al = cyc - start_cyc + 1;
      if (exp_done_q.size() == 0) begin
        bad++;
        $display("FAIL done_pulse: got done at cycle %0d, required no done", al);
      end else begin
        el = exp_done_q.pop_front();
        if (al != el) begin
          bad++;
          $display("FAIL done_latency: got %0d cycles, required %0d", al, el);
        end
      end
    end
    if (rd_req) begin
      total++;
      ar = {busy, seat_broke, rd_balance, rd_wager};
      if (exp_rd_q.size() == 0) begin
        bad++;
        $display("FAIL read: strobe with no expectation queued");
      end else begin
        er = exp_rd_q.pop_front();
        if (ar !== er) begin
          bad++;
          $display("FAIL read seat%0d: got busy=%0b broke=%b bal=%0d wag=%0d, required busy=%0b broke=%b bal=%0d wag=%0d",
                   rd_seat, ar[RD_W-1], ar[RD_W-2 -: NSEAT], ar[WAG_W +: BAL_W], ar[WAG_W-1:0],
                   er[RD_W-1], er[RD_W-2 -: NSEAT], er[WAG_W +: BAL_W], er[WAG_W-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic bet(input int seat, input logic [1:0] typ, input int amt, input logic ok);
    @(posedge clk); #1;
    bet_valid  = 1'b1;
    bet_seat   = SEAT_W'(seat);
    bet_type   = typ;
    bet_amount = WAG_W'(amt);
    exp_bet_q.push_back(ok ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    bet_valid = 1'b0;
  endtask

  task automatic rd(input int seat, input int bal, input int wag,
                    input logic [NSEAT-1:0] broke, input logic bsy);
    @(posedge clk); #1;
    rd_seat = SEAT_W'(seat);
    rd_req  = 1'b1;
    exp_rd_q.push_back({bsy, broke, BAL_W'(bal), WAG_W'(wag)});
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic settle_go(input logic [1:0] res, input logic exp_done);
    @(posedge clk); #1;
    settle_start = 1'b1;
    result       = res;
    if (exp_done) exp_done_q.push_back(NSEAT + 1);
    @(posedge clk); #1;
    start_cyc    = cyc;
    settle_start = 1'b0;
    result       = 2'b00;
  endtask

  task automatic settle_wait();
    repeat (NSEAT + 3) @(posedge clk);
  endtask

  // Stimulus
  initial begin
    resetb = 1'b0; bet_valid = 1'b0; bet_seat = '0; bet_type = 2'b00; bet_amount = '0;
    settle_start = 1'b0; result = 2'b00; rd_seat = '0;
    #23 resetb = 1'b1;

    for (int s = 0; s < NSEAT; s++) rd(s, 100, 0, 4'b0000, 1'b0);

    // player win
    bet(0, 2'b01, 10, 1'b1);
    rd(0, 90, 10, 4'b0000, 1'b0);
    settle_go(2'b01, 1'b1);
    settle_wait();
    rd(0, 110, 0, 4'b0000, 1'b0);

    // tie result: tie winner and banker push
    bet(1, 2'b11, 10, 1'b1);
    bet(2, 2'b10, 20, 1'b1);
    settle_go(2'b11, 1'b1);
    settle_wait();
    rd(1, 180, 0, 4'b0000, 1'b0);
    rd(2, 100, 0, 4'b0000, 1'b0);
    rd(3, 100, 0, 4'b0000, 1'b0);
    rd(0, 110, 0, 4'b0000, 1'b0);

    // rejections
    bet(3, 2'b01, 101, 1'b0);
    bet(3, 2'b00, 5, 1'b0);
    bet(3, 2'b01, 0, 1'b0);
    rd(3, 100, 0, 4'b0000, 1'b0);
    bet(3, 2'b01, 100, 1'b1);
    rd(3, 0, 100, 4'b1000, 1'b0);
    bet(0, 2'b10, 10, 1'b1);
    bet(0, 2'b01, 5, 1'b0);
    rd(0, 100, 10, 4'b1000, 1'b0);

    // bet while busy is rejected
    settle_go(2'b01, 1'b1);
    bet(1, 2'b01, 5, 1'b0);
    settle_wait();
    rd(0, 100, 0, 4'b0000, 1'b0);
    rd(3, 200, 0, 4'b0000, 1'b0);
    rd(1, 180, 0, 4'b0000, 1'b0);

    // start with no result is ignored
    settle_go(2'b00, 1'b0);
    settle_wait();
    rd(2, 100, 0, 4'b0000, 1'b0);

    // bet in the same cycle as an accepted start
    @(posedge clk); #1;
    bet_valid = 1'b1; bet_seat = 2'd2; bet_type = 2'b01; bet_amount = 8'd5;
    settle_start = 1'b1; result = 2'b10;
    exp_bet_q.push_back(2'b01);
    exp_done_q.push_back(NSEAT + 1);
    @(posedge clk); #1;
    start_cyc = cyc; bet_valid = 1'b0; settle_start = 1'b0; result = 2'b00;
    settle_wait();
    rd(2, 100, 0, 4'b0000, 1'b0);

    // saturation: 150 + 9*50 clips to 255
    bet(3, 2'b11, 50, 1'b1);
    settle_go(2'b11, 1'b1);
    settle_wait();
    rd(3, 255, 0, 4'b0000, 1'b0);

    // lose everything
    bet(0, 2'b10, 100, 1'b1);
    settle_go(2'b01, 1'b1);
    settle_wait();
    rd(0, 0, 0, 4'b0001, 1'b0);
    bet(0, 2'b01, 1, 1'b0);

    // reset in the middle of settlement
    bet(1, 2'b01, 80, 1'b1);
    bet(2, 2'b01, 10, 1'b1);
    settle_go(2'b01, 1'b0);
    rd(1, 100, 80, 4'b0001, 1'b1);
    resetb = 1'b0;
    #12;
    resetb = 1'b1;
    total++;
    if (state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d, required 0", state_dbg);
    end
    for (int s = 0; s < NSEAT; s++) rd(s, 100, 0, 4'b0000, 1'b0);

    repeat (4) @(posedge clk);
    total++;
    if (exp_bet_q.size() != 0) begin
      bad++;
      $display("FAIL bet_queue: %0d responses missing, required 0", exp_bet_q.size());
    end
    total++;
    if (exp_done_q.size() != 0) begin
      bad++;
      $display("FAIL done_queue: %0d done pulses missing, required 0", exp_done_q.size());
    end
    total++;
    if (exp_rd_q.size() != 0) begin
      bad++;
      $display("FAIL read_queue: %0d reads unchecked, required 0", exp_rd_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
